// File: rtl/adc_seq_collector_if.sv
// Bundles the ADC sequencer CSR port and the ADC response stream.
// master = collector side (drives CSR, sinks responses); slave = ADC side.
interface adc_seq_collector_if;
  logic        csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic        rsp_startofpacket;
  logic        rsp_endofpacket;

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata,
    input  csr_readdata,
    input  rsp_valid, rsp_channel, rsp_data, rsp_startofpacket, rsp_endofpacket
  );

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata,
    output csr_readdata,
    output rsp_valid, rsp_channel, rsp_data, rsp_startofpacket, rsp_endofpacket
  );
endinterface

// File: rtl/adc_seq_collector.sv
// Host-side ADC sequencer controller: starts/stops continuous conversion over the
// CSR port and box-car averages 2^AVG_SHIFT response samples per channel.
module adc_seq_collector #(
  parameter int NUM_CH    = 8,
  parameter int AVG_SHIFT = 2
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 enable,
  adc_seq_collector_if.master  adc,
  input  logic [4:0]           rd_ch,
  output logic [11:0]          rd_data,
  output logic [NUM_CH-1:0]    valid_mask,
  output logic                 frame_done,
  output logic                 running,
  output logic [7:0]           drop_count
);

  localparam int SW = 12 + AVG_SHIFT;
  localparam int CW = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  // With AVG_SHIFT=0 the single count bit stays 0, so every beat completes.
  localparam logic [CW-1:0] CNT_LAST = (AVG_SHIFT == 0) ? {CW{1'b0}} : {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_RUN       = 3'd2,
    S_STOP      = 3'd3,
    S_POLL      = 3'd4,
    S_POLL_WAIT = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                csr_read_r;
  logic                csr_write_r;
  logic [31:0]         csr_writedata_r;
  logic                running_r;
  logic                frame_done_r;
  logic [7:0]          drop_count_r;
  logic [NUM_CH-1:0]   valid_mask_r;
  logic [SW-1:0]       acc_r    [NUM_CH];
  logic [CW-1:0]       cnt_r    [NUM_CH];
  logic [11:0]         result_r [NUM_CH];
  logic                accept_s;
  logic                ch_ok_s;
  logic                start_clear_s;
  logic [11:0]         rd_data_s;
  logic                unused_s;

  function automatic logic [SW-1:0] acc_add(input logic [SW-1:0] acc,
                                            input logic [11:0]   sample);
    return acc + SW'(sample);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

  assign accept_s      = adc.rsp_valid && (state_r != S_IDLE);
  assign ch_ok_s       = ({27'd0, adc.rsp_channel} < 32'(NUM_CH));
  assign start_clear_s = (state_r == S_IDLE) && (next_state_s == S_START);
  assign unused_s      = ^{adc.rsp_startofpacket, adc.csr_readdata[31:1]};

  // Next-state logic for the sequencer start/stop/poll handshake.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (enable) next_state_s = S_START;
        else        next_state_s = S_IDLE;
      end
      S_START: next_state_s = S_RUN;
      S_RUN: begin
        if (!enable) next_state_s = S_STOP;
        else         next_state_s = S_RUN;
      end
      S_STOP: next_state_s = S_POLL;
      S_POLL: next_state_s = S_POLL_WAIT;
      S_POLL_WAIT: begin
        // Read latency is 1, so readdata belongs to the strobe of the previous cycle.
        if (adc.csr_readdata[0]) next_state_s = S_POLL;
        else                     next_state_s = S_IDLE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register and CSR strobes, registered from the upcoming state.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_r         <= S_IDLE;
      csr_read_r      <= 1'b0;
      csr_write_r     <= 1'b0;
      csr_writedata_r <= 32'h0000_0000;
      running_r       <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      csr_write_r     <= (next_state_s == S_START) || (next_state_s == S_STOP);
      csr_writedata_r <= (next_state_s == S_START) ? 32'h0000_0001 : 32'h0000_0000;
      csr_read_r      <= (next_state_s == S_POLL);
      running_r       <= (next_state_s != S_IDLE);
    end
  end

  // Per-channel averaging, drop counting and end-of-frame pulse.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      frame_done_r <= 1'b0;
      drop_count_r <= 8'd0;
      valid_mask_r <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i]    <= {SW{1'b0}};
        cnt_r[i]    <= {CW{1'b0}};
        result_r[i] <= 12'd0;
      end
    end else begin
      frame_done_r <= accept_s && adc.rsp_endofpacket;
      if (accept_s && !ch_ok_s) begin
        drop_count_r <= sat_inc8(drop_count_r);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (start_clear_s) begin
          acc_r[i]        <= {SW{1'b0}};
          cnt_r[i]        <= {CW{1'b0}};
          valid_mask_r[i] <= 1'b0;
        end else if (accept_s && (adc.rsp_channel == 5'(i))) begin
          if (cnt_r[i] == CNT_LAST) begin
            result_r[i]     <= 12'(acc_add(acc_r[i], adc.rsp_data) >> AVG_SHIFT);
            acc_r[i]        <= {SW{1'b0}};
            cnt_r[i]        <= {CW{1'b0}};
            valid_mask_r[i] <= 1'b1;
          end else begin
            acc_r[i] <= acc_add(acc_r[i], adc.rsp_data);
            cnt_r[i] <= cnt_r[i] + CW'(1'b1);
          end
        end
      end
    end
  end

  // Result bank read mux; out-of-range indices read as zero.
  always_comb begin
    rd_data_s = 12'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_data_s = (rd_ch == 5'(i)) ? result_r[i] : rd_data_s;
    end
  end

  assign rd_data           = rd_data_s;
  assign valid_mask        = valid_mask_r;
  assign frame_done        = frame_done_r;
  assign running           = running_r;
  assign drop_count        = drop_count_r;
  assign adc.csr_address   = 1'b0;
  assign adc.csr_read      = csr_read_r;
  assign adc.csr_write     = csr_write_r;
  assign adc.csr_writedata = csr_writedata_r;

endmodule

// File: doc/adc_seq_collector.md
Name: adc_seq_collector

Overview:
- Host-side counterpart of the modular ADC subsystem.
- Masters the ADC sequencer CSR to start and stop continuous conversion.
- Sinks the ADC response Avalon-ST stream and box-car averages 2^AVG_SHIFT samples per channel.
- Presents a per-channel result bank to downstream control logic.

Parameters:
- NUM_CH, 8: number of channels tracked (channel indices 0..NUM_CH-1, max 32).
- AVG_SHIFT, 2: log2 of samples averaged per result (0 = no averaging).

Ports:
- clk_clk  in  1  system clock; same clock as the ADC CSR and response interfaces.
- reset_reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  level; 1 = keep ADC sequencer running, 0 = stop it.
- csr_address  out  1  sequencer CSR address; always 0 (control register).
- csr_read  out  1  CSR read strobe.
- csr_write  out  1  CSR write strobe.
- csr_writedata  out  32  CSR write data.
- csr_readdata  in  32  CSR read data; fixed read latency 1.
- rsp_valid  in  1  response beat valid.
- rsp_channel  in  5  response channel index.
- rsp_data  in  12  response sample.
- rsp_startofpacket  in  1  first beat of a sequence.
- rsp_endofpacket  in  1  last beat of a sequence.
- rd_ch  in  5  result bank read index.
- rd_data  out  12  averaged result for rd_ch; 0 if rd_ch >= NUM_CH.
- valid_mask  out  NUM_CH  bit n = channel n holds at least one result since enable rose.
- frame_done  out  1  one-cycle pulse per accepted endofpacket beat.
- running  out  1  1 in states START, RUN, STOP, POLL.
- drop_count  out  8  saturating count of beats with rsp_channel >= NUM_CH.

Behaviour:
- Reset (sampled at clock edge with reset_reset_n=0):
  - State IDLE.
  - csr_read, csr_write, csr_writedata, csr_address = 0.
  - All accumulators, counts and results = 0.
  - valid_mask = 0, frame_done = 0, running = 0, drop_count = 0.
  - Reset mid-operation abandons any CSR transaction; no stop write is issued.
- No waitrequest: each CSR write or read strobe lasts exactly one cycle.
- FSM:
  - IDLE: enable=1 -> START. Also clears valid_mask and all accumulators/counts on that transition.
  - START: csr_write=1, csr_writedata=0x0000_0001 (run=1, mode=continuous), one cycle -> RUN.
  - RUN: enable=0 -> STOP.
  - STOP: csr_write=1, csr_writedata=0x0000_0000, one cycle -> POLL.
  - POLL: csr_read=1 for one cycle, then evaluate csr_readdata in the following cycle. Bit0=0 -> IDLE. Bit0=1 -> reissue the read. Read strobes are spaced 2 cycles apart.
  - enable changes during START, STOP or POLL are ignored until the FSM reaches RUN or IDLE.
- Beat acceptance: a beat is accepted when rsp_valid=1 and state != IDLE. Draining continues through STOP and POLL. Beats arriving in IDLE are discarded and are not counted as drops.
- Accepted beat with ch = rsp_channel < NUM_CH:
  - sum = acc[ch] + rsp_data, width 12+AVG_SHIFT bits; no overflow is possible.
  - If cnt[ch] = 2^AVG_SHIFT-1:
    - result[ch] <= sum >> AVG_SHIFT (truncate).
    - acc[ch] <= 0, cnt[ch] <= 0, valid_mask[ch] <= 1.
  - Otherwise: acc[ch] <= sum, cnt[ch] <= cnt[ch]+1.
  - AVG_SHIFT=0: every beat writes result directly.
  - The result is visible on rd_data the cycle after the completing beat edge.
- Accepted beat with rsp_channel >= NUM_CH: drop_count increments and saturates at 255. The beat still counts for frame_done if it is an endofpacket beat.
- frame_done: registered, high for exactly the cycle after an accepted beat with rsp_endofpacket=1.
- rsp_startofpacket carries no state function. A beat with both SOP and EOP set is legal.
- rd_data: combinational mux of result[rd_ch].

Test Plan:
- Reset, then enable=1: exactly one csr_write with data 0x1 two cycles after enable rises; running=1; no csr_read in RUN.
- AVG_SHIFT=2, ch 3 beats 100, 101, 102, 104: after the 4th beat, rd_ch=3 gives rd_data=101 (407>>2) and valid_mask[3]=1. After the 3rd beat only, valid_mask[3]=0.
- NUM_CH=8, beat on ch 9 with EOP: drop_count=1, frame_done pulses once, no result changes. Then 300 such beats: drop_count=255.
- enable=0 in RUN: csr_write with 0x0, then reads. Return readdata 0x1 twice, then 0x0: FSM goes IDLE and running=0. A beat on ch 0 during POLL is still accumulated.
- Interleaved beats ch0=4000 and ch1=8, 4 each, with EOP on every ch1 beat: result0=4000, result1=8, frame_done pulses 4 times.
- Reset asserted in the middle of POLL: next cycle all outputs are 0 and no further CSR strobes occur while enable=0.
